cmpr_share_arb: RTL and testbench

- Time-shares one not-equal/equal compare datapath among NUM_REQ requesters in the generated accelerator.
- Requesters present operands with a request. A round-robin arbiter grants one requester per cycle.
- The compare result is returned through a one-deep registered response slot with valid/ready backpressure.
- The block replaces per-operator compare macrocells wherever the scheduler has marked compares as shareable.

---
 rtl/cmpr_share_arb.sv | 122 ++++++++++++
 tb/tb_cmpr_share_arb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cmpr_share_arb.sv
// Purpose : round-robin shares one equal/not-equal comparator among NUM_REQ requesters.
// Latency : gnt is combinational in the request cycle; the result is registered one cycle later.
// Backpr. : a held response (rsp_valid && !rsp_ready) blocks all grants; requests wait and rr_ptr holds.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req/req_op/req_pred   per-requester request, op (1 = neq, 0 = eq) and predicate
//   req_i0/req_i1         packed operands, slice k belongs to requester k
//   gnt                   one-hot grant, same cycle as the accepted request
//   rsp_valid/rsp_ready   one-deep response slot handshake
//   rsp_id/rsp_o0/rsp_enable  granted requester index, zero-extended result, registered predicate
module cmpr_share_arb #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_i0,
    input  logic [NUM_REQ*WIDTH-1:0]   req_i1,
    input  logic [NUM_REQ-1:0]         req_op,
    input  logic [NUM_REQ-1:0]         req_pred,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_WIDTH-1:0]        rsp_id,
    output logic [WIDTH-1:0]           rsp_o0,
    output logic                       rsp_enable
);

    localparam logic [ID_WIDTH:0]   NREQ_EXT = (ID_WIDTH+1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(NUM_REQ-1);

    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] gnt_idx;
    logic [ID_WIDTH-1:0] scan_idx;
    logic [ID_WIDTH:0]   scan_sum;
    logic                gnt_any;
    logic                can_issue;
    logic [WIDTH-1:0]    sel_i0;
    logic [WIDTH-1:0]    sel_i1;
    logic                sel_op;
    logic                sel_pred;
    logic                outt;

    // The slot can take a new result if it is empty or being drained this cycle.
    assign can_issue = !rsp_valid || rsp_ready;

    // Scan requesters starting at rr_ptr, wrapping at NUM_REQ; first hit wins.
    // The extra sum bit keeps rr_ptr + i from overflowing before the wrap.
    // rst_n is included so no grant is ever shown while reset is held.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        if (rst_n && can_issue) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                scan_sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(i);
                if (scan_sum >= NREQ_EXT) begin
                    scan_sum = scan_sum - NREQ_EXT;
                end
                scan_idx = scan_sum[ID_WIDTH-1:0];
                if (!gnt_any && req[scan_idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = scan_idx;
                end
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Operand mux onto the single shared comparator.
    always_comb begin
        sel_i0   = '0;
        sel_i1   = '0;
        sel_op   = 1'b0;
        sel_pred = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == ID_WIDTH'(k)) begin
                sel_i0   = req_i0[k*WIDTH +: WIDTH];
                sel_i1   = req_i1[k*WIDTH +: WIDTH];
                sel_op   = req_op[k];
                sel_pred = req_pred[k];
            end
        end
    end

    assign outt = sel_op ? (sel_i0 != sel_i1) : (sel_i0 == sel_i1);

    // Round-robin pointer: moves just past the winner, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Response slot: a grant overwrites it (no bubble even while draining),
    // a drain without a grant only clears valid and leaves the data fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_o0     <= '0;
            rsp_enable <= 1'b0;
        end else if (gnt_any) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= gnt_idx;
            rsp_o0     <= WIDTH'(outt);
            rsp_enable <= sel_pred;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmpr_share_arb.sv
module tb_cmpr_share_arb;

    localparam int NUM_REQ  = 4;
    localparam int WIDTH    = 4;
    localparam int ID_WIDTH = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_i0;
    logic [NUM_REQ*WIDTH-1:0] req_i1;
    logic [NUM_REQ-1:0]       req_op;
    logic [NUM_REQ-1:0]       req_pred;
    logic [NUM_REQ-1:0]       gnt;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_WIDTH-1:0]      rsp_id;
    logic [WIDTH-1:0]         rsp_o0;
    logic                     rsp_enable;

    int n_chk;
    int n_bad;

    cmpr_share_arb #(
        .NUM_REQ  (NUM_REQ),
        .WIDTH    (WIDTH),
        .ID_WIDTH (ID_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_i0     (req_i0),
        .req_i1     (req_i1),
        .req_op     (req_op),
        .req_pred   (req_pred),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_o0     (rsp_o0),
        .rsp_enable (rsp_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [3:0] a, input logic [3:0] b,
                           input logic op, input logic pred);
        req_i0[k*WIDTH +: WIDTH] = a;
        req_i1[k*WIDTH +: WIDTH] = b;
        req_op[k]   = op;
        req_pred[k] = pred;
    endtask

    initial begin
        int e;
        n_chk     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        req       = 4'b1111;
        req_i0    = '0;
        req_i1    = '0;
        req_op    = '0;
        req_pred  = '0;
        rsp_ready = 1'b1;

        // Reset held with all requests up: nothing granted, slot empty.
        #2;
        chk("rst_gnt",   32'(gnt), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_o0",    32'(rsp_o0), 0);
        chk("rst_id",    32'(rsp_id), 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("first_gnt", 32'(gnt), 'b0001);
        step();                          // grant 0 -> rr_ptr=1
        req = '0;
        #1;
        chk("first_valid", 32'(rsp_valid), 1);
        chk("first_id",    32'(rsp_id), 0);
        step();                          // drained, no grant
        chk("drain_valid", 32'(rsp_valid), 0);

        // Single not-equal request from requester 2.
        set_req(2, 4'hA, 4'h5, 1'b1, 1'b1);
        req = 4'b0100;
        #1;
        chk("neq_gnt", 32'(gnt), 'b0100);
        step();                          // rr_ptr=3
        req = '0;
        #1;
        chk("neq_valid", 32'(rsp_valid), 1);
        chk("neq_id",    32'(rsp_id), 2);
        chk("neq_o0",    32'(rsp_o0), 1);
        chk("neq_en",    32'(rsp_enable), 1);

        // Equal op on requester 1: match then mismatch, back to back.
        set_req(1, 4'h7, 4'h7, 1'b0, 1'b0);
        req = 4'b0010;
        #1;
        chk("eq_gnt0", 32'(gnt), 'b0010);
        step();
        set_req(1, 4'h7, 4'h6, 1'b0, 1'b0);
        #1;
        chk("eq_o0_a",  32'(rsp_o0), 1);
        chk("eq_id_a",  32'(rsp_id), 1);
        chk("eq_en_a",  32'(rsp_enable), 0);
        chk("eq_gnt1",  32'(gnt), 'b0010);
        step();                          // rr_ptr=2
        req = '0;
        #1;
        chk("eq_valid_b", 32'(rsp_valid), 1);
        chk("eq_o0_b",    32'(rsp_o0), 0);

        // Bring rr_ptr to 0 via a grant to requester 3.
        set_req(3, 4'h0, 4'h0, 1'b0, 1'b1);
        req = 4'b1000;
        step();

        // Round robin: every requester up, eq op with i0=k, i1=1 -> only id 1 yields 1.
        for (int k = 0; k < NUM_REQ; k++) begin
            set_req(k, 4'(k), 4'h1, 1'b0, 1'b1);
        end
        req = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            e = n % 4;
            #1;
            chk("rr_gnt", 32'(gnt), 32'(1 << e));
            step();
            chk("rr_id", 32'(rsp_id), 32'(e));
            chk("rr_o0", 32'(rsp_o0), (e == 1) ? 1 : 0);
        end

        // Wrap: after a grant to 3, requesters 0 and 3 up -> 0 wins.
        req = 4'b1000;
        #1;
        chk("wrap_gnt3", 32'(gnt), 'b1000);
        step();
        set_req(0, 4'h5, 4'h5, 1'b0, 1'b1);
        req = 4'b1001;
        #1;
        chk("wrap_gnt0", 32'(gnt), 'b0001);
        step();                          // slot: id 0, o0=1, en=1; rr_ptr=1

        // Backpressure: slot stalls for 3 cycles with requester 1 waiting.
        set_req(1, 4'h3, 4'h3, 1'b1, 1'b0);
        req       = 4'b0010;
        rsp_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("bp_gnt",   32'(gnt), 0);
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_id",    32'(rsp_id), 0);
            chk("bp_o0",    32'(rsp_o0), 1);
            chk("bp_en",    32'(rsp_enable), 1);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_gnt", 32'(gnt), 'b0010);
        step();                          // rr_ptr=2
        req = '0;
        #1;
        chk("bp_new_valid", 32'(rsp_valid), 1);
        chk("bp_new_id",    32'(rsp_id), 1);
        chk("bp_new_o0",    32'(rsp_o0), 0);
        chk("bp_new_en",    32'(rsp_enable), 0);
        step();
        chk("bp_drain", 32'(rsp_valid), 0);

        // Reset mid-stream: fill the slot (grant 2 -> rr_ptr=3), then stall and reset off-edge.
        req = 4'b0100;
        step();
        req       = '0;
        rsp_ready = 1'b0;
        #1;
        chk("mid_valid_pre", 32'(rsp_valid), 1);
        #1;
        rst_n = 1'b0;
        req   = 4'b1010;
        #1;
        chk("mid_valid_async", 32'(rsp_valid), 0);
        chk("mid_id_async",    32'(rsp_id), 0);
        chk("mid_gnt_rst",     32'(gnt), 0);
        step();
        rst_n = 1'b1;
        #1;
        // With rr_ptr back at 0, requester 1 beats 3 (rr_ptr=3 would have picked 3).
        chk("mid_ptr_gnt", 32'(gnt), 'b0010);
        req = 4'b1000;
        #1;
        chk("mid_gnt3", 32'(gnt), 'b1000);
        step();
        req = '0;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 1);
        chk("mid_rsp_id",    32'(rsp_id), 3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
